// File: rtl/triple_loader.sv
// Collects a valid/ready sample stream into registered a/b/c triples for the downstream sorter.
// Optional idle-timeout padding of partial triples is enabled by defining TRIPLE_LOADER_PAD_EN.
module triple_loader #(
    parameter int W         = 4,
    parameter int CNT_W     = 8,
    parameter int TIMEOUT   = 16,
    parameter int PAD_VALUE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [W-1:0]     a,
    output logic [W-1:0]     b,
    output logic [W-1:0]     c,
    output logic             triple_valid,
    input  logic             triple_ready,
    output logic [1:0]       fill_cnt,
    output logic [CNT_W-1:0] triple_cnt,
    output logic             padded
);

    typedef enum logic [1:0] {FILL0, FILL1, FILL2, HOLD} state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             padded_q, padded_d;
    logic             accept;
    logic             timeout;

`ifdef TRIPLE_LOADER_PAD_EN
    localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [IDLE_W-1:0] idle_q, idle_d;

    // Counts consecutive no-accept cycles in FILL1/FILL2; timeout fires on the TIMEOUT-th one.
    always_comb begin
        timeout = 1'b0;
        idle_d  = '0;
        if (!flush && !accept && (state_q == FILL1 || state_q == FILL2)) begin
            if (idle_q == IDLE_W'(TIMEOUT - 1)) timeout = 1'b1;
            else                                idle_d  = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idle_q <= '0;
        else        idle_q <= idle_d;
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{32'(TIMEOUT), 32'(PAD_VALUE)};
    assign timeout    = 1'b0;
`endif

    assign in_ready = ((state_q != HOLD) | triple_ready) & ~flush;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        cnt_d    = cnt_q;
        padded_d = padded_q;
        if (flush) begin
            state_d  = FILL0;
            padded_d = 1'b0;
        end else begin
            unique case (state_q)
                FILL0: begin
                    if (accept) begin
                        a_d     = in_data;
                        state_d = FILL1;
                    end
                end
                FILL1: begin
                    if (accept) begin
                        b_d     = in_data;
                        state_d = FILL2;
                    end else if (timeout) begin
                        b_d      = W'(PAD_VALUE);
                        c_d      = W'(PAD_VALUE);
                        padded_d = 1'b1;
                        state_d  = HOLD;
                    end
                end
                FILL2: begin
                    if (accept) begin
                        c_d      = in_data;
                        padded_d = 1'b0;
                        state_d  = HOLD;
                    end else if (timeout) begin
                        c_d      = W'(PAD_VALUE);
                        padded_d = 1'b1;
                        state_d  = HOLD;
                    end
                end
                HOLD: begin
                    // Consume and start the next triple in the same cycle when a sample is offered.
                    if (triple_ready) begin
                        cnt_d    = cnt_q + 1'b1;
                        padded_d = 1'b0;
                        if (accept) begin
                            a_d     = in_data;
                            state_d = FILL1;
                        end else begin
                            state_d = FILL0;
                        end
                    end
                end
                default: state_d = FILL0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FILL0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            cnt_q    <= '0;
            padded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            cnt_q    <= cnt_d;
            padded_q <= padded_d;
        end
    end

    always_comb begin
        unique case (state_q)
            FILL1:   fill_cnt = 2'd1;
            FILL2:   fill_cnt = 2'd2;
            default: fill_cnt = 2'd0;
        endcase
    end

    assign a            = a_q;
    assign b            = b_q;
    assign c            = c_q;
    assign triple_valid = (state_q == HOLD);
    assign triple_cnt   = cnt_q;
    assign padded       = padded_q;

endmodule

// File: tb/tb_triple_loader.sv
// Scoreboard bench for triple_loader: stimulus queues expected triples, a monitor checks each consume.
// Define TRIPLE_LOADER_PAD_EN for both files to exercise the padding build.
module tb_triple_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic [3:0] a, b, c;
    logic       triple_valid;
    logic       triple_ready;
    logic [1:0] fill_cnt;
    logic [7:0] triple_cnt;
    logic       padded;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [12:0] exp_q[$];

    triple_loader #(.W(4), .CNT_W(8), .TIMEOUT(16), .PAD_VALUE(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .a(a), .b(b), .c(c), .triple_valid(triple_valid),
        .triple_ready(triple_ready), .fill_cnt(fill_cnt), .triple_cnt(triple_cnt), .padded(padded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Each consume handshake (observed at negedge) must match the next queued triple.
    always @(negedge clk) begin
        if (rst_n && triple_valid && triple_ready) begin
            if (exp_q.size() == 0) chk("unexpected_triple", {19'b0, a, b, c, padded}, 32'h0);
            else                   chk("triple", {19'b0, a, b, c, padded}, {19'b0, exp_q.pop_front()});
        end
    end

    task automatic send(input logic [3:0] d);
        int unsigned n;
        n        = 0;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_abc"}, {20'b0, a, b, c}, 32'h0);
        chk({name, "_valid"}, 32'(triple_valid), 32'd0);
        chk({name, "_fill"}, 32'(fill_cnt), 32'd0);
        chk({name, "_cnt"}, 32'(triple_cnt), 32'd0);
        chk({name, "_padded"}, 32'(padded), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; flush = 1'b0; triple_ready = 1'b0;
        #12;
        chk_zero("reset");
        @(negedge clk); rst_n = 1'b1;
        tick(1);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // 1: back-to-back 3,9,5 with consumer ready
        triple_ready = 1'b1;
        exp_q.push_back({4'd3, 4'd9, 4'd5, 1'b0});
        send(4'd3); send(4'd9); send(4'd5);
        chk("t1_valid", 32'(triple_valid), 32'd1);
        tick(1);
        chk("t1_cnt", 32'(triple_cnt), 32'd1);
        chk("t1_valid_drop", 32'(triple_valid), 32'd0);

        // 2: back-pressure while a triple is pending
        triple_ready = 1'b0;
        exp_q.push_back({4'd1, 4'd2, 4'd3, 1'b0});
        send(4'd1); send(4'd2); send(4'd3);
        in_data = 4'd7; in_valid = 1'b1;
        tick(2);
        chk("t2_in_ready", 32'(in_ready), 32'd0);
        chk("t2_hold_abc", {20'b0, a, b, c}, 32'h123);
        chk("t2_hold_valid", 32'(triple_valid), 32'd1);
        triple_ready = 1'b1;
        tick(1);
        in_valid = 1'b0;
        chk("t2_refill_a", 32'(a), 32'd7);
        chk("t2_refill_fill", 32'(fill_cnt), 32'd1);
        chk("t2_cnt", 32'(triple_cnt), 32'd2);
        exp_q.push_back({4'd7, 4'd10, 4'd11, 1'b0});
        send(4'd10); send(4'd11);
        tick(1);
        chk("t2_cnt_b", 32'(triple_cnt), 32'd3);

        // 3: flush a partial triple, then flush a pending one
        send(4'd4); send(4'd6);
        chk("t3_fill2", 32'(fill_cnt), 32'd2);
        flush = 1'b1; in_valid = 1'b1; in_data = 4'd13;
        @(negedge clk);
        chk("t3_flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("t3_flush_fill", 32'(fill_cnt), 32'd0);
        chk("t3_flush_a", 32'(a), 32'd4);
        exp_q.push_back({4'd8, 4'd8, 4'd8, 1'b0});
        send(4'd8); send(4'd8); send(4'd8);
        tick(1);
        chk("t3_cnt", 32'(triple_cnt), 32'd4);
        triple_ready = 1'b0;
        send(4'd1); send(4'd1); send(4'd1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        chk("t3_hold_flush_valid", 32'(triple_valid), 32'd0);
        chk("t3_hold_flush_cnt", 32'(triple_cnt), 32'd4);

        // 4: asynchronous reset mid-triple and during HOLD
        send(4'd5); send(4'd6);
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_mid");
        @(negedge clk); rst_n = 1'b1;
        tick(1);
        send(4'd2); send(4'd3); send(4'd4);
        chk("t4_hold_valid", 32'(triple_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_hold");
        @(negedge clk); rst_n = 1'b1;
        triple_ready = 1'b1;
        tick(3);
        chk("t4_no_stale_valid", 32'(triple_valid), 32'd0);
        chk("t4_no_stale_fill", 32'(fill_cnt), 32'd0);

        // 5: triple counter wrap
        for (int unsigned i = 0; i < 255; i++) begin
            exp_q.push_back({4'(i), 4'(i + 1), 4'(i + 2), 1'b0});
            send(4'(i)); send(4'(i + 1)); send(4'(i + 2));
        end
        tick(1);
        chk("t5_cnt255", 32'(triple_cnt), 32'd255);
        exp_q.push_back({4'd15, 4'd0, 4'd1, 1'b0});
        send(4'd15); send(4'd0); send(4'd1);
        tick(1);
        chk("t5_wrap", 32'(triple_cnt), 32'd0);

        // 6: idle behaviour of a partial triple
        triple_ready = 1'b0;
        send(4'd12);
`ifdef TRIPLE_LOADER_PAD_EN
        tick(15);
        chk("t6_before_timeout", 32'(triple_valid), 32'd0);
        tick(1);
        chk("t6_pad_valid", 32'(triple_valid), 32'd1);
        chk("t6_pad_abc", {20'b0, a, b, c}, 32'hc00);
        chk("t6_padded", 32'(padded), 32'd1);
        exp_q.push_back({4'd12, 4'd0, 4'd0, 1'b1});
        triple_ready = 1'b1;
        tick(1);
        chk("t6_padded_clear", 32'(padded), 32'd0);
`else
        tick(100);
        chk("t6_still_fill1", 32'(fill_cnt), 32'd1);
        chk("t6_no_valid", 32'(triple_valid), 32'd0);
        chk("t6_padded", 32'(padded), 32'd0);
        exp_q.push_back({4'd12, 4'd1, 4'd2, 1'b0});
        triple_ready = 1'b1;
        send(4'd1); send(4'd2);
        tick(1);
`endif
        tick(2);
        chk("queue_drained", exp_q.size(), 32'd0);
        chk("final_cnt", 32'(triple_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
